sar_search_ctrl: RTL

SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

---
 rtl/sar_search_ctrl_if.sv | 26 ++
 rtl/sar_search_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl_if.sv
// Comparator-facing bus of the SAR search controller: start request, trial word out,
// comparator flags back in, and the search status/result.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] trial;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        output start, cmp_gt, cmp_eq, cmp_lt,
        input  trial, busy, done, result, found, err
    );

    modport slave (
        input  start, cmp_gt, cmp_eq, cmp_lt,
        output trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Purpose: successive-approximation search of a target via an external magnitude comparator.
// Latency: WIDTH TRY cycles + 1 VERIFY cycle, done pulses the cycle after; SAR_EARLY_EXIT_EN can finish on the first equal trial.
// Backpressure: none; start is sampled only in IDLE and dropped otherwise (no queuing).
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        TRY,
        VERIFY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [WIDTH-1:0] trial, trial_nxt;
    logic [WIDTH-1:0] result, result_nxt;
    logic             found, found_nxt;
    logic             err, err_nxt;
    logic [WIDTH-1:0] kept;
    logic             flags_ok;

    assign flags_ok = $onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt});

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        trial_nxt  = trial;
        result_nxt = result;
        found_nxt  = found;
        err_nxt    = err;
        // Bit under test survives unless the target is below the trial.
        kept       = trial;
        if (bus.cmp_lt) begin
            kept[idx] = 1'b0;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt  = TRY;
                    idx_nxt    = IDX_W'(WIDTH - 1);
                    trial_nxt  = TOP_BIT;
                    result_nxt = '0;
                    found_nxt  = 1'b0;
                    err_nxt    = 1'b0;
                end
            end
            TRY: begin
                if (!flags_ok) begin
                    state_nxt  = DONE;
                    trial_nxt  = '0;
                    result_nxt = '0;
                    found_nxt  = 1'b0;
                    err_nxt    = 1'b1;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (bus.cmp_eq) begin
                    state_nxt  = DONE;
                    result_nxt = trial;
                    found_nxt  = 1'b1;
                end
`endif
                else if (idx != '0) begin
                    idx_nxt            = idx - IDX_W'(1);
                    trial_nxt          = kept;
                    trial_nxt[idx_nxt] = 1'b1;
                end else begin
                    state_nxt = VERIFY;
                    trial_nxt = kept;
                end
            end
            VERIFY: begin
                state_nxt = DONE;
                if (!flags_ok) begin
                    trial_nxt  = '0;
                    result_nxt = '0;
                    found_nxt  = 1'b0;
                    err_nxt    = 1'b1;
                end else begin
                    result_nxt = trial;
                    found_nxt  = bus.cmp_eq;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            trial  <= trial_nxt;
            result <= result_nxt;
            found  <= found_nxt;
            err    <= err_nxt;
        end
    end

    assign bus.trial  = trial;
    assign bus.result = result;
    assign bus.found  = found;
    assign bus.err    = err;
    assign bus.busy   = (state == TRY) || (state == VERIFY);
    assign bus.done   = (state == DONE);
endmodule
